// File: rtl/attack_scheduler.sv
// attack_scheduler: runs one enemy attack turn as a frame-paced sequence of
// arrows. Each arrow waits a gap, flies for a fixed number of frames, and is
// then resolved as blocked or hit against the player's rotate input.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no turn active, waiting for a start edge
// GAP     | counting frame ticks before the next arrow spawns
// FLIGHT  | arrow in flight, progress counts frame ticks
// RESOLVE | single cycle, compare rotate_in against the arrow direction
// DONE    | single cycle, turn finished (finished_out high)
module attack_scheduler #(
    parameter logic [3:0] START_STATE   = 4'b1000,
    parameter int         NUM_ARROWS    = 24,
    parameter int         SPAWN_GAP     = 30,
    parameter int         TRAVEL_FRAMES = 60,
    parameter int         MAX_HP        = 20,
    parameter int         DAMAGE        = 4,
    parameter int         H_TICK        = 0,
    parameter int         V_TICK        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [3:0]  state_in,
    input  logic [3:0]  turn_in,
    input  logic [1:0]  rotate_in,
    output logic        busy_out,
    output logic        finished_out,
    output logic        arrow_valid_out,
    output logic [4:0]  arrow_idx_out,
    output logic [1:0]  arrow_dir_out,
    output logic [7:0]  arrow_progress_out,
    output logic        hit_pulse_out,
    output logic        block_pulse_out,
    output logic [4:0]  hits_out,
    output logic [4:0]  blocks_out,
    output logic [7:0]  hp_out
);

    localparam logic [10:0] H_TICK_C    = 11'(H_TICK);
    localparam logic [9:0]  V_TICK_C    = 10'(V_TICK);
    localparam logic [4:0]  LAST_IDX    = 5'(NUM_ARROWS - 1);
    localparam logic [15:0] GAP_LAST    = 16'(SPAWN_GAP - 1);
    localparam logic [7:0]  TRAVEL_LAST = 8'(TRAVEL_FRAMES - 1);
    localparam logic [7:0]  HP_INIT     = 8'(MAX_HP);
    localparam logic [7:0]  DMG         = 8'(DAMAGE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_FLIGHT,
        S_RESOLVE,
        S_DONE
    } state_t;

    state_t      state;
    logic        tick;
    logic        start_match_q;
    logic        start_match;
    logic        start;
    logic [2:0]  turn_l;
    logic [4:0]  idx;
    logic [15:0] gap_cnt;
    logic [7:0]  progress;
    logic [4:0]  hits;
    logic [4:0]  blocks;
    logic [7:0]  hp;
    logic        hit_q;
    logic        block_q;
    logic [1:0]  dir_base;
    logic        arrow_hit;
    logic [7:0]  hp_after_hit;
    logic [7:0]  hp_next;
    logic        unused_turn_msb;

    // Only the low three turn bits shape the pattern.
    assign unused_turn_msb = turn_in[3];

    assign start_match  = (state_in == START_STATE);
    assign start        = start_match && !start_match_q;

    assign dir_base      = idx[1:0] + turn_l[1:0];
    assign arrow_dir_out = turn_l[2] ? ~dir_base : dir_base;

    assign arrow_hit    = (rotate_in != arrow_dir_out);
    assign hp_after_hit = (hp < DMG) ? 8'd0 : hp - DMG;
    assign hp_next      = arrow_hit ? hp_after_hit : hp;

    assign busy_out           = (state != S_IDLE);
    assign finished_out       = (state == S_DONE);
    assign arrow_valid_out    = (state == S_FLIGHT);
    assign arrow_idx_out      = idx;
    assign arrow_progress_out = progress;
    assign hit_pulse_out      = hit_q;
    assign block_pulse_out    = block_q;
    assign hits_out           = hits;
    assign blocks_out         = blocks;
    assign hp_out             = hp;

    // Frame tick and start-edge history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick          <= 1'b0;
            start_match_q <= 1'b0;
        end else begin
            tick          <= (hcount_in == H_TICK_C) && (vcount_in == V_TICK_C);
            start_match_q <= start_match;
        end
    end

    // Turn sequencer: gap, flight, resolve per arrow, then done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            turn_l   <= 3'd0;
            idx      <= 5'd0;
            gap_cnt  <= 16'd0;
            progress <= 8'd0;
            hits     <= 5'd0;
            blocks   <= 5'd0;
            hp       <= HP_INIT;
            hit_q    <= 1'b0;
            block_q  <= 1'b0;
        end else begin
            hit_q   <= 1'b0;
            block_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        turn_l  <= turn_in[2:0];
                        idx     <= 5'd0;
                        hits    <= 5'd0;
                        blocks  <= 5'd0;
                        gap_cnt <= 16'd0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt  <= 16'd0;
                            progress <= 8'd0;
                            state    <= S_FLIGHT;
                        end else begin
                            gap_cnt <= gap_cnt + 16'd1;
                        end
                    end
                end
                S_FLIGHT: begin
                    if (tick) begin
                        if (progress == TRAVEL_LAST) begin
                            state <= S_RESOLVE;
                        end else begin
                            progress <= progress + 8'd1;
                        end
                    end
                end
                S_RESOLVE: begin
                    if (arrow_hit) begin
                        hit_q <= 1'b1;
                        hits  <= hits + 5'd1;
                        hp    <= hp_after_hit;
                    end else begin
                        block_q <= 1'b1;
                        blocks  <= blocks + 5'd1;
                    end
                    // A drained HP bar ends the turn even mid-sequence.
                    if ((idx == LAST_IDX) || (hp_next == 8'd0)) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 5'd1;
                        state <= S_GAP;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_attack_scheduler.sv
// Directed bench for attack_scheduler: two instances share stimulus, one with
// MAX_HP=20 and one with MAX_HP=8 so the early-end path runs alongside.
module tb_attack_scheduler;

    logic        clk;
    logic        rst;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [3:0]  state_in;
    logic [3:0]  turn_in;
    logic [1:0]  rotate_in;

    logic        busy_a, fin_a, valid_a, hit_a, blk_a;
    logic [4:0]  idx_a, hits_a, blocks_a;
    logic [1:0]  dir_a;
    logic [7:0]  prog_a, hp_a;

    logic        busy_b, fin_b, valid_b, hit_b, blk_b;
    logic [4:0]  idx_b, hits_b, blocks_b;
    logic [1:0]  dir_b;
    logic [7:0]  prog_b, hp_b;

    int n_cmp = 0;
    int n_err = 0;

    // monitor counters
    int nblk = 0, nhit = 0, nfin = 0, nfin2 = 0, narr2 = 0;
    int busy_cur = 0, busy_last = 0;
    logic busy_q = 1'b0, valid2_q = 1'b0;

    attack_scheduler #(
        .NUM_ARROWS(3), .SPAWN_GAP(2), .TRAVEL_FRAMES(4), .MAX_HP(20), .DAMAGE(4)
    ) dut (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .state_in(state_in), .turn_in(turn_in), .rotate_in(rotate_in),
        .busy_out(busy_a), .finished_out(fin_a), .arrow_valid_out(valid_a),
        .arrow_idx_out(idx_a), .arrow_dir_out(dir_a), .arrow_progress_out(prog_a),
        .hit_pulse_out(hit_a), .block_pulse_out(blk_a), .hits_out(hits_a),
        .blocks_out(blocks_a), .hp_out(hp_a)
    );

    attack_scheduler #(
        .NUM_ARROWS(3), .SPAWN_GAP(2), .TRAVEL_FRAMES(4), .MAX_HP(8), .DAMAGE(4)
    ) dut2 (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .state_in(state_in), .turn_in(turn_in), .rotate_in(rotate_in),
        .busy_out(busy_b), .finished_out(fin_b), .arrow_valid_out(valid_b),
        .arrow_idx_out(idx_b), .arrow_dir_out(dir_b), .arrow_progress_out(prog_b),
        .hit_pulse_out(hit_b), .block_pulse_out(blk_b), .hits_out(hits_b),
        .blocks_out(blocks_b), .hp_out(hp_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Raster stand-in: one frame tick every 4 clocks.
    initial begin
        int phase;
        phase = 0;
        hcount_in = 11'd5;
        vcount_in = 10'd5;
        forever begin
            @(negedge clk);
            phase = (phase + 1) % 4;
            if (phase == 0) begin
                hcount_in = 11'd0;
                vcount_in = 10'd0;
            end else begin
                hcount_in = 11'd5;
                vcount_in = 10'd5;
            end
        end
    end

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (blk_a === 1'b1) nblk <= nblk + 1;
        if (hit_a === 1'b1) nhit <= nhit + 1;
        if (fin_a === 1'b1) nfin <= nfin + 1;
        if (fin_b === 1'b1) nfin2 <= nfin2 + 1;
        if ((valid_b === 1'b1) && !valid2_q) narr2 <= narr2 + 1;
        valid2_q <= (valid_b === 1'b1);
        if (busy_a === 1'b1) begin
            busy_cur <= busy_cur + 1;
        end else if (busy_q) begin
            busy_last <= busy_cur;
            busy_cur  <= 0;
        end
        busy_q <= (busy_a === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) until arrow_valid of the main instance equals want.
    task automatic wait_valid(input string tag, input logic want, output int cycles);
        cycles = 0;
        while ((valid_a !== want) && (cycles < 300)) begin
            @(negedge clk);
            cycles++;
        end
        chk(tag, (cycles < 300), 1);
    endtask

    initial begin
        int n;
        int s_fin, s_blk, s_hit, s_fin2, s_arr2;
        logic [1:0] exp_dir [3];

        rst = 1'b1;
        state_in = 4'd0;
        turn_in = 4'd0;
        rotate_in = 2'd0;
        repeat (3) @(negedge clk);

        // reset defaults
        chk("rst_hp", hp_a, 20);
        chk("rst_hp_b", hp_b, 8);
        chk("rst_busy", busy_a, 0);
        chk("rst_fin", fin_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_idx", idx_a, 0);
        chk("rst_dir", dir_a, 0);
        chk("rst_prog", prog_a, 0);
        chk("rst_pulses", {hit_a, blk_a}, 0);
        chk("rst_counts", {hits_a, blocks_a}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy_a, 0);

        // turn 1: turn 0, every arrow blocked
        s_fin = nfin; s_blk = nblk; s_hit = nhit;
        state_in = 4'd8;
        turn_in = 4'd0;
        @(negedge clk);
        chk("t1_busy_rise", busy_a, 1);
        for (int k = 0; k < 3; k++) begin
            wait_valid("t1_valid_rise_timeout", 1'b1, n);
            chk("t1_dir", dir_a, k);
            chk("t1_idx", idx_a, k);
            chk("t1_prog0", prog_a, 0);
            rotate_in = 2'(k);
            wait_valid("t1_valid_fall_timeout", 1'b0, n);
            chk("t1_valid_len", n, 16);
            chk("t1_resolve_no_pulse", {hit_a, blk_a}, 0);
            chk("t1_prog_hold", prog_a, 3);
            @(negedge clk);
            chk("t1_block_pulse", {hit_a, blk_a}, 2'b01);
            chk("t1_blocks", blocks_a, k + 1);
            chk("t1_fin", fin_a, (k == 2) ? 1 : 0);
        end
        @(negedge clk);
        chk("t1_busy_fall", busy_a, 0);
        chk("t1_fin_clear", fin_a, 0);
        @(negedge clk);
        chk("t1_busy_len", (busy_last >= 68) && (busy_last <= 76), 1);
        chk("t1_hits", hits_a, 0);
        chk("t1_blocks_final", blocks_a, 3);
        chk("t1_hp", hp_a, 20);
        chk("t1_fin_count", nfin - s_fin, 1);
        chk("t1_blk_count", nblk - s_blk, 3);
        chk("t1_hit_count", nhit - s_hit, 0);
        chk("t1_b_blocks", blocks_b, 3);
        chk("t1_b_hp", hp_b, 8);

        // level held after the turn must not retrigger
        repeat (40) @(negedge clk);
        chk("held_no_retrigger", busy_a, 0);
        chk("held_fin_count", nfin - s_fin, 1);
        chk("held_hits_persist", {hits_a, blocks_a}, {5'd0, 5'd3});

        // turn 2: inverted pattern, rotate held at 0
        state_in = 4'd0;
        @(negedge clk);
        turn_in = 4'd5;
        rotate_in = 2'd0;
        state_in = 4'd8;
        s_fin = nfin; s_fin2 = nfin2; s_arr2 = narr2;
        exp_dir[0] = 2'd2;
        exp_dir[1] = 2'd1;
        exp_dir[2] = 2'd0;
        for (int k = 0; k < 3; k++) begin
            wait_valid("t2_valid_rise_timeout", 1'b1, n);
            chk("t2_dir", dir_a, exp_dir[k]);
            wait_valid("t2_valid_fall_timeout", 1'b0, n);
            chk("t2_valid_len", n, 16);
            @(negedge clk);
            chk("t2_pulse", {hit_a, blk_a}, (k == 2) ? 2'b01 : 2'b10);
            if (k == 0) begin
                chk("t2_hp_after_first", hp_a, 16);
                // second rising edge and a turn change mid-turn: both ignored
                state_in = 4'd0;
                @(negedge clk);
                state_in = 4'd8;
                turn_in = 4'd0;
            end
            if (k == 1) begin
                chk("t2_b_early_fin", fin_b, 1);
                chk("t2_b_hit_pulse", hit_b, 1);
                chk("t2_b_hp", hp_b, 0);
            end
        end
        chk("t2_fin", fin_a, 1);
        repeat (60) @(negedge clk);
        chk("t2_hits", hits_a, 2);
        chk("t2_blocks", blocks_a, 1);
        chk("t2_hp", hp_a, 12);
        chk("t2_fin_count", nfin - s_fin, 1);
        chk("t2_busy_after", busy_a, 0);
        chk("t2_b_hits", hits_b, 2);
        chk("t2_b_blocks", blocks_b, 0);
        chk("t2_b_arrows", narr2 - s_arr2, 2);
        chk("t2_b_fin_count", nfin2 - s_fin2, 1);

        // turn 3: new edge, hp persists, every arrow misses
        state_in = 4'd0;
        @(negedge clk);
        turn_in = 4'd0;
        rotate_in = 2'd3;
        state_in = 4'd8;
        s_fin = nfin; s_fin2 = nfin2; s_arr2 = narr2;
        wait_valid("t3_valid_rise_timeout", 1'b1, n);
        chk("t3_hp_persist", hp_a, 12);
        chk("t3_counts_cleared", {hits_a, blocks_a}, 0);
        chk("t3_dir0", dir_a, 0);
        n = 0;
        while ((fin_a !== 1'b1) && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        chk("t3_fin_timeout", (n < 400), 1);
        repeat (3) @(negedge clk);
        chk("t3_hits", hits_a, 3);
        chk("t3_blocks", blocks_a, 0);
        chk("t3_hp", hp_a, 0);
        chk("t3_fin_count", nfin - s_fin, 1);
        chk("t3_b_hits", hits_b, 1);
        chk("t3_b_arrows", narr2 - s_arr2, 1);
        chk("t3_b_fin_count", nfin2 - s_fin2, 1);

        // reset in the middle of a flight
        state_in = 4'd0;
        @(negedge clk);
        state_in = 4'd8;
        s_fin = nfin;
        wait_valid("t4_valid_rise_timeout", 1'b1, n);
        repeat (3) @(negedge clk);
        chk("t4_in_flight", valid_a, 1);
        rst = 1'b1;
        state_in = 4'd0;
        @(negedge clk);
        chk("t4_busy", busy_a, 0);
        chk("t4_valid", valid_a, 0);
        chk("t4_hp", hp_a, 20);
        chk("t4_b_hp", hp_b, 8);
        chk("t4_fin", fin_a, 0);
        chk("t4_prog", prog_a, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_fin_count", nfin - s_fin, 0);
        chk("t4_still_idle", busy_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
